// File: rtl/mfda_seq_pkg.sv
// Shared types for the assay step sequencer: program step payload, FSM states,
// pump phase table and the dwell-load helper.
package mfda_seq_pkg;

  localparam int unsigned SEQ_NUM_VALVES = 8;
  localparam int unsigned SEQ_DWELL_W    = 16;
  localparam int unsigned PUMP_PHASES    = 6;

  typedef struct packed {
    logic [SEQ_NUM_VALVES-1:0] valves;
    logic [SEQ_DWELL_W-1:0]    dwell;
    logic                      last;
  } step_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_e;

  // Entry 0 is the first phase driven when a run begins.
  localparam logic [PUMP_PHASES-1:0][2:0] PUMP_SEQ = {
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  // Remaining-cycle count to load for a step; a dwell of 0 still holds one cycle.
  function automatic logic [SEQ_DWELL_W-1:0] dwell_load(input logic [SEQ_DWELL_W-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - SEQ_DWELL_W'(1);
  endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Six-phase peristaltic pump driver: PUMP_DIV-cycle divider plus phase counter,
// restarting at phase 0 on the first running cycle and forced to 000 otherwise.
module pump_phase_gen
  import mfda_seq_pkg::*;
#(
  parameter int unsigned PUMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_next_i,
  input  logic       running_i,
  output logic [2:0] pump_o
);

  localparam int unsigned DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [2:0]       phase_q;
  logic [2:0]       pump_q;
  logic [2:0]       phase_nxt_c;

  assign phase_nxt_c = (phase_q == 3'(PUMP_PHASES - 1)) ? 3'd0 : phase_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= '0;
      pump_q  <= '0;
    end else if (!run_next_i) begin
      div_q   <= '0;
      phase_q <= '0;
      pump_q  <= '0;
    end else if (!running_i) begin
      div_q   <= '0;
      phase_q <= '0;
      pump_q  <= PUMP_SEQ[0];
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      phase_q <= phase_nxt_c;
      pump_q  <= PUMP_SEQ[phase_nxt_c];
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  assign pump_o = pump_q;

endmodule

// File: rtl/assay_step_sequencer.sv
// Programmable valve-pattern sequencer: plays a DEPTH-step program of valve
// patterns and dwell times. Optional pump drive under PERISTALTIC_PUMP_EN.
module assay_step_sequencer
  import mfda_seq_pkg::*;
#(
  parameter int unsigned NUM_VALVES = SEQ_NUM_VALVES,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DWELL_W    = SEQ_DWELL_W,
  parameter int unsigned PUMP_DIV   = 4,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [NUM_VALVES-1:0] cfg_valves,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic                  cfg_last,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [NUM_VALVES-1:0] valve_o,
  output logic [AW-1:0]         step_idx,
  output logic [2:0]            pump_o
);

  // The step payload width is fixed by the package; reject mismatched overrides.
  if ((NUM_VALVES != SEQ_NUM_VALVES) || (DWELL_W != SEQ_DWELL_W)) begin : g_bad_width
    $error("NUM_VALVES/DWELL_W must match mfda_seq_pkg step_t widths");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (PUMP_DIV < 1) begin : g_bad_div
    $error("PUMP_DIV must be >= 1");
  end

  step_t                 prog_q [DEPTH];
  seq_state_e            state_q;
  logic [DWELL_W-1:0]    cnt_q;
  logic [AW-1:0]         idx_q;
  logic [NUM_VALVES-1:0] valve_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;

  step_t                 cur_step_c;
  step_t                 nxt_step_c;
  logic [AW-1:0]         nxt_idx_c;
  logic                  step_end_c;

  assign cur_step_c = prog_q[idx_q];
  assign nxt_idx_c  = idx_q + AW'(1);
  assign nxt_step_c = prog_q[nxt_idx_c];
  assign step_end_c = (cnt_q == '0);

  // Program register file: writable only while no program is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        prog_q[i] <= '0;
      end
    end else if (cfg_we && !busy_q) begin
      prog_q[cfg_addr] <= '{valves: cfg_valves, dwell: cfg_dwell, last: cfg_last};
    end
  end

  // Sequencer FSM; cnt_q holds the cycles left in the current step after this one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      valve_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            valve_q <= prog_q[0].valves;
            cnt_q   <= dwell_load(prog_q[0].dwell);
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            valve_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
          end else if (step_end_c) begin
            if (cur_step_c.last) begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              valve_q <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= nxt_idx_c;
              valve_q <= nxt_step_c.valves;
              cnt_q   <= dwell_load(nxt_step_c.dwell);
            end
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign valve_o  = valve_q;
  assign step_idx = idx_q;

`ifdef PERISTALTIC_PUMP_EN
  logic busy_d_c;

  // Busy value after the coming edge, so the pump phase lines up with busy.
  assign busy_d_c = ((state_q == ST_IDLE) && start && !abort) ||
                    ((state_q == ST_RUN) && !abort && !(step_end_c && cur_step_c.last));

  pump_phase_gen #(
    .PUMP_DIV (PUMP_DIV)
  ) u_pump (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_next_i (busy_d_c),
    .running_i  (busy_q),
    .pump_o     (pump_o)
  );
`else
  assign pump_o = 3'b000;
`endif

endmodule

// File: tb/tb_assay_step_sequencer.sv
// Self-checking bench for assay_step_sequencer: directed scenarios plus random
// programs compared per cycle against a step-list expansion model.
module tb_assay_step_sequencer;

  localparam int unsigned NV   = 8;
  localparam int unsigned DEP  = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned PDIV = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [NV-1:0] cfg_valves = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          cfg_last = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, aborted;
  logic [NV-1:0] valve_o;
  logic [1:0]    step_idx;
  logic [2:0]    pump_o;

  always #5 clk = ~clk;

  assay_step_sequencer #(
    .NUM_VALVES (NV),
    .DEPTH      (DEP),
    .DWELL_W    (DW),
    .PUMP_DIV   (PDIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_valves (cfg_valves),
    .cfg_dwell  (cfg_dwell),
    .cfg_last   (cfg_last),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .valve_o    (valve_o),
    .step_idx   (step_idx),
    .pump_o     (pump_o)
  );

  typedef struct packed {
    logic [7:0] valve;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] pump;
  } obs_t;

  obs_t       obs_q[$];
  obs_t       exp_q[$];
  logic [7:0] m_valves [DEP];
  int         m_dwell  [DEP];
  bit         m_last   [DEP];
  int         checks = 0;
  int         passes = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("v=%02h idx=%0d busy=%b done=%b abrt=%b pump=%03b",
                     o.valve, o.idx, o.busy, o.done, o.aborted, o.pump);
  endfunction

  function automatic logic [2:0] pump_exp(input int k);
`ifdef PERISTALTIC_PUMP_EN
    logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    return seq[(k / int'(PDIV)) % 6];
`else
    return 3'b000 | 3'(k * 0);
`endif
  endfunction

  // Expand the model program into a per-cycle trace starting at the first busy cycle.
  task automatic gen_expected(input int n, input int abort_at);
    int   s, k, rem, fin;
    obs_t e;
    exp_q.delete();
    s = 0; k = 0; fin = 0;
    rem = (m_dwell[0] == 0) ? 1 : m_dwell[0];
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (fin == 0) begin
        e.valve = m_valves[s];
        e.idx   = 2'(s);
        e.busy  = 1'b1;
        e.pump  = pump_exp(k);
        k++;
        rem--;
        if (rem == 0) begin
          if (m_last[s]) fin = 1;
          else begin
            s   = (s + 1) % int'(DEP);
            rem = (m_dwell[s] == 0) ? 1 : m_dwell[s];
          end
        end
      end else if (fin == 1) begin
        e.done = 1'b1;
        fin    = 2;
      end
      exp_q.push_back(e);
    end
    if (abort_at >= 0 && abort_at < n - 1 && exp_q[abort_at].busy) begin
      for (int j = abort_at + 1; j < n; j++) exp_q[j] = '0;
      e = '0;
      e.aborted = 1'b1;
      exp_q[abort_at + 1] = e;
    end
  endtask

  task automatic prog_write(input int a, input logic [7:0] v, input int d, input bit l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_valves = v; cfg_dwell = 16'(d); cfg_last = l;
    @(negedge clk);
    cfg_we = 1'b0;
    m_valves[a] = v; m_dwell[a] = d; m_last[a] = l;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEP); i++) begin
      m_valves[i] = '0; m_dwell[i] = 0; m_last[i] = 1'b0;
    end
  endtask

  // Sample outputs each negedge; optionally pulse/hold start, inject abort or a config write.
  task automatic capture(input int n, input bit hold, input int abort_at,
                         input int we_at, input logic [1:0] we_addr, input logic [7:0] we_val);
    obs_t o;
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o.valve = valve_o; o.idx = busy ? step_idx : 2'd0; o.busy = busy;
      o.done = done; o.aborted = aborted; o.pump = pump_o;
      obs_q.push_back(o);
      if (!hold) start = 1'b0;
      abort  = (i == abort_at);
      cfg_we = (i == we_at);
      if (i == we_at) begin
        cfg_addr = we_addr; cfg_valves = we_val; cfg_dwell = 16'd5; cfg_last = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({valve_o, step_idx, busy, done, aborted, pump_o} !== '0)
      $display("FAIL reset_held: got v=%02h idx=%0d b=%b d=%b a=%b p=%03b, expected all 0",
               valve_o, step_idx, busy, done, aborted, pump_o);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({valve_o, step_idx, busy, done, aborted, pump_o} !== '0)
      $display("FAIL reset_release: got v=%02h idx=%0d b=%b d=%b a=%b p=%03b, expected all 0",
               valve_o, step_idx, busy, done, aborted, pump_o);
    else passes++;
    clear_model();
  endtask

  task automatic test_basic_run();
    int nb, nd;
    prog_write(0, 8'h01, 2, 1'b0);
    prog_write(1, 8'h06, 3, 1'b0);
    prog_write(2, 8'h80, 1, 1'b1);
    capture(9, 1'b0, -1, -1, 2'd0, 8'h00);
    gen_expected(9, -1);
    nb = 0; nd = 0;
    for (int i = 0; i < 9; i++) begin
      nb += int'(obs_q[i].busy);
      nd += int'(obs_q[i].done);
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL basic[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
    checks++;
    if (nb !== 6) $display("FAIL basic_busy_len: got %0d, expected 6", nb); else passes++;
    checks++;
    if (nd !== 1) $display("FAIL basic_done_count: got %0d, expected 1", nd); else passes++;
  endtask

  task automatic test_zero_dwell();
    prog_write(0, 8'hFF, 0, 1'b1);
    capture(4, 1'b0, -1, -1, 2'd0, 8'h00);
    gen_expected(4, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL zero_dwell[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_wrap_abort();
    int nd;
    for (int i = 0; i < int'(DEP); i++) prog_write(i, 8'($urandom), 1, 1'b0);
    capture(9, 1'b0, 5, -1, 2'd0, 8'h00);
    gen_expected(9, 5);
    nd = 0;
    for (int i = 0; i < 9; i++) begin
      nd += int'(obs_q[i].done);
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wrap_abort[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
    checks++;
    if (nd !== 0) $display("FAIL wrap_no_done: got %0d done pulses, expected 0", nd); else passes++;
  endtask

  task automatic test_abort_last();
    prog_write(0, 8'h3C, 2, 1'b0);
    prog_write(1, 8'hC3, 3, 1'b1);
    capture(8, 1'b0, 4, -1, 2'd0, 8'h00);
    gen_expected(8, 4);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL abort_last[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_write_while_busy();
    prog_write(0, 8'h11, 3, 1'b0);
    prog_write(1, 8'h22, 2, 1'b1);
    capture(8, 1'b0, -1, 1, 2'd1, 8'hAA);
    gen_expected(8, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wr_busy_run[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
    capture(8, 1'b0, -1, -1, 2'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wr_busy_readback[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
    prog_write(1, 8'hAA, 1, 1'b1);
    capture(6, 1'b0, -1, -1, 2'd0, 8'h00);
    gen_expected(6, -1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL wr_idle_lands[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_restart_held();
    obs_t first[$];
    prog_write(0, 8'h5A, 2, 1'b1);
    gen_expected(4, -1);
    first = exp_q;
    exp_q = {first, first};
    capture(8, 1'b1, -1, -1, 2'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL restart_held[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, aborted, done, valve_o} !== '0)
        $display("FAIL start_abort_idle[%0d]: got b=%b a=%b d=%b v=%02h, expected all 0", i, busy, aborted, done, valve_o);
      else passes++;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_pump();
    prog_write(0, 8'h0F, 20, 1'b1);
    capture(23, 1'b0, -1, -1, 2'd0, 8'h00);
    gen_expected(23, -1);
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL pump[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_reset_mid_run();
    prog_write(0, 8'h77, 10, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || valve_o !== 8'h77)
      $display("FAIL mid_run_active: got b=%b v=%02h, expected b=1 v=77", busy, valve_o);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valve_o, step_idx, busy, done, aborted, pump_o} !== '0)
      $display("FAIL mid_run_reset: got v=%02h idx=%0d b=%b d=%b a=%b p=%03b, expected all 0",
               valve_o, step_idx, busy, done, aborted, pump_o);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    capture(8, 1'b0, 5, -1, 2'd0, 8'h00);
    gen_expected(8, 5);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL mem_cleared[%0d]: got %s, expected %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
      else passes++;
    end
  endtask

  task automatic test_random_programs();
    int len, total, n, ab;
    for (int it = 0; it < 20; it++) begin
      len = int'($urandom_range(1, DEP));
      total = 0;
      for (int s = 0; s < len; s++) begin
        prog_write(s, 8'($urandom), int'($urandom_range(0, 4)), s == len - 1);
        total += (m_dwell[s] == 0) ? 1 : m_dwell[s];
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      n  = total + 3;
      capture(n, 1'b0, ab, -1, 2'd0, 8'h00);
      gen_expected(n, ab);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL random%0d[%0d]: got %s, expected %s", it, i, fmt(obs_q[i]), fmt(exp_q[i]));
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_dwell();
    test_wrap_abort();
    test_abort_last();
    test_write_while_busy();
    test_restart_held();
    test_start_abort_idle();
    test_pump();
    test_reset_mid_run();
    test_random_programs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
